ws2812_layer_out_dbuf: RTL and testbench

- Next-generation single-layer WS2812 output channel with a parametrised LED count and 3-byte (GRB) or 4-byte (GRBW) pixels.
- Owns a double-buffered pixel RAM; the upstream layer writer fills the back bank while the front bank is serialised.
- Emits the NRZ waveform with cycle-count timing parameters, a reset/latch gap, a frame-done pulse and queued frame requests.
- Sits between the layer write bus and one LED strip pin.

---
 rtl/ws2812_layer_out_dbuf.sv | 156 +++++++++++++++
 tb/tb_ws2812_layer_out_dbuf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812_layer_out_dbuf.sv
// Single-layer WS2812 output channel: double-buffered pixel RAM, NRZ serialiser,
// latch gap, frame-done pulse and one-deep queued frame request.
module ws2812_layer_out_dbuf #(
  parameter int LED_NUM       = 64,
  parameter int BYTES_PER_LED = 3,
  parameter int ADDR_W        = 6,
  parameter int T_BIT_CYC     = 100,
  parameter int T0H_CYC       = 32,
  parameter int T1H_CYC       = 64,
  parameter int T_RST_CYC     = 24000
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     layer_en_in,
  input  logic                     frame_rdy_in,
  input  logic [ADDR_W-1:0]        wr_addr_in,
  input  logic [BYTES_PER_LED-1:0] byte_en_in,
  input  logic [7:0]               byte_data_in,
  output logic                     busy_out,
  output logic                     frame_done_out,
  output logic                     ws2812_data_out
);
  localparam int NBYTES = LED_NUM * BYTES_PER_LED;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMAX   = (T_BIT_CYC > T_RST_CYC) ? T_BIT_CYC : T_RST_CYC;
  localparam int TMR_W  = $clog2(TMAX + 1);

  localparam logic [TMR_W-1:0] BIT_END   = TMR_W'(T_BIT_CYC - 1);
  localparam logic [TMR_W-1:0] T0H_END   = TMR_W'(T0H_CYC - 1);
  localparam logic [TMR_W-1:0] T1H_END   = TMR_W'(T1H_CYC - 1);
  localparam logic [TMR_W-1:0] RST_END   = TMR_W'(T_RST_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, RST} state_t;

  typedef struct packed {
    logic                     en;
    logic [ADDR_W-1:0]        addr;
    logic [BYTES_PER_LED-1:0] be;
    logic [7:0]               data;
  } wr_req_t;

  state_t           state, state_nxt;
  wr_req_t          wr;
  logic             front_sel;
  logic             pending;
  logic [TMR_W-1:0] tmr;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [IDX_W-1:0] byte_idx, rd_idx;
  logic [7:0]       rd_byte;
  logic [7:0]       rd_bank0 [NBYTES];
  logic [7:0]       rd_bank1 [NBYTES];
  logic             hi_end, bit_end, rst_end, last_bit, swap;
  logic             line_q, done_q;

  assign wr = {layer_en_in, wr_addr_in, byte_en_in, byte_data_in};

  // One cell per pixel byte; writes always land in the bank not being shown.
  // Out-of-range addresses match no cell and are dropped.
  for (genvar l = 0; l < LED_NUM; l++) begin : g_led
    for (genvar k = 0; k < BYTES_PER_LED; k++) begin : g_byte
      logic [7:0] b0, b1;
      logic       we;
      assign we = wr.en && wr.be[k] && (wr.addr == ADDR_W'(l));
      always_ff @(posedge clk_in) begin
        if (we && front_sel)  b0 <= wr.data;
        if (we && !front_sel) b1 <= wr.data;
      end
      assign rd_bank0[l*BYTES_PER_LED+k] = b0;
      assign rd_bank1[l*BYTES_PER_LED+k] = b1;
    end
  end

  // Next byte is read while the last bit of the current byte runs out,
  // so bit periods stay back-to-back.
  assign rd_idx  = (state == LOAD) ? '0 : byte_idx + 1'b1;
  assign rd_byte = front_sel ? rd_bank1[rd_idx] : rd_bank0[rd_idx];

  assign hi_end   = (tmr == (shreg[7] ? T1H_END : T0H_END));
  assign bit_end  = (tmr == BIT_END);
  assign rst_end  = (state == RST) && (tmr == RST_END);
  assign last_bit = (bit_idx == 3'd7) && (byte_idx == LAST_BYTE);
  assign swap     = (state_nxt == LOAD);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_rdy_in) state_nxt = LOAD;
      LOAD:    state_nxt = BIT_HI;
      BIT_HI:  if (hi_end) state_nxt = BIT_LO;
      BIT_LO:  if (bit_end) state_nxt = last_bit ? RST : BIT_HI;
      RST:     if (rst_end) state_nxt = (pending || frame_rdy_in) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      front_sel <= 1'b0;
      pending   <= 1'b0;
      tmr       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      line_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= rst_end;
      line_q <= (state_nxt == BIT_HI);
      if (swap) front_sel <= ~front_sel;
      // A request arriving exactly at the end of the gap is served by the restart.
      if (rst_end)                          pending <= 1'b0;
      else if (frame_rdy_in && state != IDLE) pending <= 1'b1;
      case (state)
        LOAD: begin
          shreg    <= rd_byte;
          bit_idx  <= '0;
          byte_idx <= '0;
          tmr      <= '0;
        end
        BIT_HI: tmr <= tmr + 1'b1;
        BIT_LO: begin
          if (bit_end) begin
            tmr <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (last_bit) begin
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                shreg    <= rd_byte;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {shreg[6:0], 1'b0};
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RST:     tmr <= rst_end ? '0 : tmr + 1'b1;
        default: tmr <= '0;
      endcase
    end
  end

  assign busy_out        = (state != IDLE);
  assign frame_done_out  = done_q;
  assign ws2812_data_out = line_q;
endmodule

// File: tb/tb_ws2812_layer_out_dbuf.sv
// Bench for ws2812_layer_out_dbuf: GRB (2 LEDs) and GRBW (1 LED) instances share
// stimulus; a frame-level reference model predicts line/busy/done every cycle.
module tb_ws2812_layer_out_dbuf;
  localparam int TB = 10, T0 = 3, T1 = 6, TR = 20;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, rdy = 1'b0;
  logic [1:0] addr = '0;
  logic [3:0] be = '0;
  logic [7:0] data = '0;
  logic [1:0] busy, done, line;

  always #5 clk = ~clk;

  ws2812_layer_out_dbuf #(.LED_NUM(2), .BYTES_PER_LED(3), .ADDR_W(2), .T_BIT_CYC(TB),
    .T0H_CYC(T0), .T1H_CYC(T1), .T_RST_CYC(TR)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .layer_en_in(en), .frame_rdy_in(rdy),
    .wr_addr_in(addr), .byte_en_in(be[2:0]), .byte_data_in(data),
    .busy_out(busy[0]), .frame_done_out(done[0]), .ws2812_data_out(line[0]));

  ws2812_layer_out_dbuf #(.LED_NUM(1), .BYTES_PER_LED(4), .ADDR_W(2), .T_BIT_CYC(TB),
    .T0H_CYC(T0), .T1H_CYC(T1), .T_RST_CYC(TR)) u_dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .layer_en_in(en), .frame_rdy_in(rdy),
    .wr_addr_in(addr), .byte_en_in(be), .byte_data_in(data),
    .busy_out(busy[1]), .frame_done_out(done[1]), .ws2812_data_out(line[1]));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame = time window of 1 + bits*TB + TR cycles from the
  // accepting edge; waveform derived from a byte snapshot taken at that edge.
  int         leds[2] = '{2, 1};
  int         bpl[2]  = '{3, 4};
  logic [7:0] bank[2][2][8];
  logic [7:0] fr[2][8];
  bit         mbusy[2], mpend[2], fsel[2];
  int         mstart[2], mend[2];
  logic [2:0] exp_w[2] = '{3'b0, 3'b0};
  int         cyc = 0;

  function automatic int flen(input int d);
    return 1 + leds[d] * bpl[d] * 8 * TB + TR;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int o, bi, p, bk;
    logic [7:0] bv;
    bit start, mdone, ln;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mbusy[d] = 0; mpend[d] = 0; fsel[d] = 0; exp_w[d] = '0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        bk = fsel[d] ? 0 : 1;
        if (en && int'(addr) < leds[d])
          for (int k = 0; k < bpl[d]; k++)
            if (be[k]) bank[d][bk][int'(addr) * bpl[d] + k] = data;
        start = 0; mdone = 0;
        if (mbusy[d] && cyc == mend[d]) begin
          mdone = 1;
          if (mpend[d] || rdy) begin start = 1; mpend[d] = 0; end
          else mbusy[d] = 0;
        end else if (rdy) begin
          if (mbusy[d]) mpend[d] = 1;
          else start = 1;
        end
        if (start) begin
          fsel[d] = ~fsel[d];
          mbusy[d] = 1; mstart[d] = cyc; mend[d] = cyc + flen(d);
          for (int j = 0; j < 8; j++) fr[d][j] = bank[d][fsel[d] ? 1 : 0][j];
        end
        o = cyc - mstart[d]; ln = 0;
        if (mbusy[d] && o >= 1 && o <= leds[d] * bpl[d] * 8 * TB) begin
          bi = (o - 1) / TB; p = (o - 1) % TB;
          bv = fr[d][bi / 8];
          ln = (p < (bv[7 - (bi % 8)] ? T1 : T0));
        end
        exp_w[d] = {mbusy[d], mdone, ln};
      end
    end
  end

  int done_cnt[2] = '{0, 0}, fall_cnt[2] = '{0, 0};
  bit pbusy[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "wave_grb" : "wave_grbw", {29'd0, busy[d], done[d], line[d]}, {29'd0, exp_w[d]});
      if (done[d]) done_cnt[d]++;
      if (pbusy[d] && !busy[d]) fall_cnt[d]++;
      pbusy[d] = busy[d];
    end
  end

  task automatic wr(input logic e, input logic [1:0] a, input logic [3:0] s, input logic [7:0] v);
    @(negedge clk); en = e; addr = a; be = s; data = v; rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); en = 1'b0; be = '0; rdy = 1'b0; end
  endtask

  task automatic pulse();
    @(negedge clk); en = 1'b0; be = '0; rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
  endtask

  task automatic run_frame(input int n, output int b0, output int b1, output int d0,
                           output int d1, output int first0);
    @(negedge clk); en = 1'b0; be = '0; rdy = 1'b1;
    b0 = 0; b1 = 0; d0 = 0; d1 = 0; first0 = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk); rdy = 1'b0;
      if (busy[0]) b0++;
      if (busy[1]) b1++;
      if (done[0]) d0++;
      if (done[1]) d1++;
      if (line[0] && first0 < 0) first0 = i;
    end
  endtask

  initial begin
    int b0, b1, d0, d1, f0, c0, c1, q0, q1;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", {26'd0, busy, done, line}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // LED0 = {80,00,01} (+W=5A for GRBW), LED1 all FF
    wr(1, 0, 4'b0001, 8'h80); wr(1, 0, 4'b0010, 8'h00); wr(1, 0, 4'b0100, 8'h01);
    wr(1, 0, 4'b1000, 8'h5A); wr(1, 1, 4'b1111, 8'hFF);
    run_frame(560, b0, b1, d0, d1, f0);
    chk("first_high", f0, 2);
    chk("busy_len_grb", b0, 501);
    chk("busy_len_grbw", b1, 341);
    chk("done_once_grb", d0, 1);
    chk("done_once_grbw", d1, 1);

    // fill the other bank, then overwrite LED0 mid-frame
    wr(1, 0, 4'b1111, 8'h3C); wr(1, 1, 4'b1111, 8'hC3);
    pulse(); idle(100);
    wr(1, 0, 4'b1111, 8'hFF);
    idle(500);
    run_frame(560, b0, b1, d0, d1, f0);
    chk("iso_busy_len", b0, 501);
    chk("iso_done", d0, 1);

    // queued: one request from idle, two while busy
    c0 = done_cnt[0]; c1 = done_cnt[1]; q0 = fall_cnt[0]; q1 = fall_cnt[1];
    pulse(); idle(50); pulse(); idle(50); pulse();
    idle(1200);
    chk("queue_done_grb", done_cnt[0] - c0, 2);
    chk("queue_falls_grb", fall_cnt[0] - q0, 1);
    chk("queue_done_grbw", done_cnt[1] - c1, 2);
    chk("queue_falls_grbw", fall_cnt[1] - q1, 1);

    // write filtering
    wr(0, 0, 4'b0111, 8'h55);
    wr(1, 2, 4'b1111, 8'h66);
    wr(1, 0, 4'b0010, 8'h77);
    run_frame(560, b0, b1, d0, d1, f0);
    chk("filt_busy_len", b0, 501);

    // reset during the high phase of bit 5
    pulse(); idle(51);
    @(negedge clk);
    chk("pre_reset_line", line[0], 1'b1);
    c0 = done_cnt[0];
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {28'd0, busy, line}, 32'd0);
    idle(2);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(30);
    chk("mid_reset_no_done", done_cnt[0] - c0, 0);
    run_frame(560, b0, b1, d0, d1, f0);
    chk("post_reset_busy", b0, 501);
    chk("post_reset_done", d0, 1);
    chk("post_reset_first", f0, 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en = 1'($urandom); addr = 2'($urandom); be = 4'($urandom);
      data = 8'($urandom); rdy = ($urandom_range(0, 149) == 0);
    end
    idle(1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
